// File: rtl/audio_mixer_seq_if.sv
// Bus bundle for audio_mixer_seq: sample strobe, channel/mute payload, gain port and mix results.
// master drives stimulus and gain writes; slave is the mixer.
interface audio_mixer_seq_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CHANNELS  = 8,
  parameter int unsigned GAIN_BITS = 4,
  parameter int unsigned OUT_WIDTH = WIDTH + 1
);
  localparam int unsigned SEL_W = $clog2(CHANNELS);

  logic                          sample_tick;
  logic [CHANNELS*WIDTH-1:0]     channels;
  logic [CHANNELS-1:0]           mute;
  logic                          gain_we;
  logic [SEL_W-1:0]              gain_sel;
  logic [GAIN_BITS-1:0]          gain_data;
  logic [OUT_WIDTH-1:0]          out;
  logic                          out_valid;
  logic                          busy;
  logic                          overrun;

  modport master (
    output sample_tick, channels, mute, gain_we, gain_sel, gain_data,
    input  out, out_valid, busy, overrun
  );

  modport slave (
    input  sample_tick, channels, mute, gain_we, gain_sel, gain_data,
    output out, out_valid, busy, overrun
  );
endinterface

// File: rtl/audio_mixer_seq.sv
// Time-multiplexed audio mixer: snapshot on sample_tick, one gained channel accumulated per clock.
// Build option AUDIO_MIXER_SATURATE_EN: clamp the scaled result instead of wrapping it.
module audio_mixer_seq #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CHANNELS  = 8,
  parameter int unsigned GAIN_BITS = 4,
  parameter int unsigned SHIFT     = 2,
  parameter int unsigned OUT_WIDTH = WIDTH + 1
) (
  input  logic             clk,
  input  logic             rst,
  audio_mixer_seq_if.slave bus
);
  localparam int unsigned IDX_W     = $clog2(CHANNELS);
  localparam int unsigned PROD_W    = WIDTH + GAIN_BITS;
  localparam int unsigned CONTRIB_W = WIDTH + 1;
  localparam int unsigned ACC_W     = WIDTH + 1 + $clog2(CHANNELS);
  localparam int unsigned WIDE_W    = ACC_W + OUT_WIDTH;
  localparam logic [GAIN_BITS-1:0] UNITY_GAIN = GAIN_BITS'(1) << (GAIN_BITS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_start;
  logic                   w_acc_en;
  logic                   w_load_out;
  logic                   w_last;

  logic [WIDTH-1:0]       r_snap_ch [CHANNELS];
  logic [CHANNELS-1:0]    r_snap_mute;
  logic [GAIN_BITS-1:0]   r_gain [CHANNELS];
  logic [IDX_W-1:0]       r_idx;
  logic [ACC_W-1:0]       r_acc;
  logic [OUT_WIDTH-1:0]   r_out;
  logic                   r_out_valid;
  logic                   r_busy;
  logic                   r_overrun;

  logic [WIDTH-1:0]       w_sample;
  logic [GAIN_BITS-1:0]   w_gain;
  logic [PROD_W-1:0]      w_prod;
  logic [CONTRIB_W-1:0]   w_contrib;
  logic [ACC_W-1:0]       w_shifted;
  logic [WIDE_W-1:0]      w_wide;
  logic [OUT_WIDTH-1:0]   w_result;

  assign w_last = (r_idx == IDX_W'(CHANNELS - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath strobes
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_acc_en    = 1'b0;
    w_load_out  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.sample_tick) begin
          w_start     = 1'b1;
          w_state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        w_acc_en = 1'b1;
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_load_out  = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Contribution of the channel selected by r_idx, computed at full product width
  assign w_sample  = r_snap_ch[r_idx];
  assign w_gain    = r_gain[r_idx];
  assign w_prod    = PROD_W'(w_sample) * PROD_W'(w_gain);
  assign w_contrib = r_snap_mute[r_idx] ? '0 : CONTRIB_W'(w_prod >> (GAIN_BITS - 1));

  assign w_shifted = r_acc >> SHIFT;
  assign w_wide    = WIDE_W'(w_shifted);

`ifdef AUDIO_MIXER_SATURATE_EN
  assign w_result = (w_wide > WIDE_W'({OUT_WIDTH{1'b1}})) ? {OUT_WIDTH{1'b1}}
                                                         : OUT_WIDTH'(w_wide);
`else
  assign w_result = OUT_WIDTH'(w_wide);
`endif

  // Gain registers; a write lands after the current edge's accumulation read
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(CHANNELS); k++) begin
        r_gain[k] <= UNITY_GAIN;
      end
    end else if (bus.gain_we && (32'(bus.gain_sel) < CHANNELS)) begin
      r_gain[bus.gain_sel] <= bus.gain_data;
    end
  end

  // Snapshot, accumulator and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(CHANNELS); k++) begin
        r_snap_ch[k] <= '0;
      end
      r_snap_mute <= '0;
      r_idx       <= '0;
      r_acc       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_out_valid <= w_load_out;
      r_busy      <= (w_state_nxt != IDLE);
      if (bus.sample_tick && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end
      if (w_start) begin
        for (int k = 0; k < int'(CHANNELS); k++) begin
          r_snap_ch[k] <= bus.channels[k*WIDTH +: WIDTH];
        end
        r_snap_mute <= bus.mute;
        r_idx       <= '0;
        r_acc       <= '0;
      end
      if (w_acc_en) begin
        r_acc <= r_acc + ACC_W'(w_contrib);
        r_idx <= r_idx + IDX_W'(1);
      end
      if (w_load_out) begin
        r_out <= w_result;
      end
    end
  end

  assign bus.out       = r_out;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_audio_mixer_seq.sv
// Scoreboard bench for audio_mixer_seq: expected mixes are queued at tick time and
// compared when out_valid pulses; timing, overrun, gain and reset behaviour checked inline.
module tb_audio_mixer_seq;
  localparam int unsigned WIDTH     = 8;
  localparam int unsigned CHANNELS  = 8;
  localparam int unsigned GAIN_BITS = 4;
  localparam int unsigned SHIFT     = 2;
  localparam int unsigned OUT_WIDTH = 9;

  logic clk;
  logic rst;

  int unsigned n_vec;
  int unsigned n_err;
  int unsigned exp_q[$];
  int unsigned m_gain[CHANNELS];

  audio_mixer_seq_if #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .GAIN_BITS(GAIN_BITS), .OUT_WIDTH(OUT_WIDTH)
  ) bus ();

  audio_mixer_seq #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .GAIN_BITS(GAIN_BITS),
    .SHIFT(SHIFT), .OUT_WIDTH(OUT_WIDTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference mix from the bench's own gain copy
  function automatic int unsigned model(input logic [CHANNELS*WIDTH-1:0] chv,
                                        input logic [CHANNELS-1:0] mv);
    int unsigned sum = 0;
    int unsigned res;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      if (!mv[k]) sum += (int'(chv[k*WIDTH +: WIDTH]) * m_gain[k]) >> (GAIN_BITS - 1);
    end
    res = sum >> SHIFT;
`ifdef AUDIO_MIXER_SATURATE_EN
    if (res > 511) res = 511;
`else
    res = res & 511;
`endif
    return res;
  endfunction

  // Compare every out_valid pulse against the head of the scoreboard
  always begin
    @(posedge clk);
    #1;
    if (bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) check_val("spurious_valid", 32'd1, 32'd0);
      else check_val("mix_out", 32'(bus.out), 32'(exp_q.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_models();
    for (int k = 0; k < int'(CHANNELS); k++) m_gain[k] = 8;
  endtask

  task automatic write_gain(input int sel, input int unsigned data);
    bus.gain_we   = 1'b1;
    bus.gain_sel  = 3'(sel);
    bus.gain_data = 4'(data);
    step();
    bus.gain_we = 1'b0;
    m_gain[sel] = data;
  endtask

  // Drive inputs, queue the expected result and strobe one tick (edge E)
  task automatic start_mix(input logic [CHANNELS*WIDTH-1:0] chv, input logic [CHANNELS-1:0] mv);
    bus.channels    = chv;
    bus.mute        = mv;
    exp_q.push_back(model(chv, mv));
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      check_val("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CHANNELS*WIDTH-1:0] all255;
    logic [CHANNELS*WIDTH-1:0] all100;
    logic [CHANNELS*WIDTH-1:0] chv;
    n_vec = 0;
    n_err = 0;
    all255 = {CHANNELS{8'd255}};
    all100 = {CHANNELS{8'd100}};
    rst = 1'b1;
    bus.sample_tick = 1'b0;
    bus.channels    = '0;
    bus.mute        = '0;
    bus.gain_we     = 1'b0;
    bus.gain_sel    = '0;
    bus.gain_data   = '0;
    reset_models();
    repeat (3) step();
    rst = 1'b0;
    step();

    // 1: reset state, latency and busy window
    check_val("rst_out", 32'(bus.out), 32'd0);
    check_val("rst_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_overrun", 32'(bus.overrun), 32'd0);
    start_mix(all255, '0);
    check_val("busy_after_E", 32'(bus.busy), 32'd1);
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k <= 8) check_val("valid_early", 32'(bus.out_valid), 32'd0);
      if (k == 8) check_val("busy_E8", 32'(bus.busy), 32'd1);
      if (k == 9) begin
        check_val("valid_E9", 32'(bus.out_valid), 32'd1);
        check_val("busy_E9", 32'(bus.busy), 32'd0);
      end
      if (k == 10) begin
        check_val("valid_one_cycle", 32'(bus.out_valid), 32'd0);
        check_val("out_held", 32'(bus.out), 32'd510);
      end
    end
    check_val("lat_queue_empty", 32'(exp_q.size()), 32'd0);

    // 2: mute mask
    start_mix(all100, 8'b1111_0000);
    drain();

    // Gain write at the edge channel 0 is accumulated uses the old gain
    start_mix(all255, '0);
    bus.gain_we = 1'b1; bus.gain_sel = 3'd0; bus.gain_data = 4'd0;
    step();
    bus.gain_we = 1'b0;
    m_gain[0] = 0;
    drain();
    start_mix(all255, '0);
    drain();

    // 3: single channel at gain 15
    write_gain(0, 15);
    for (int k = 1; k < int'(CHANNELS); k++) write_gain(k, 0);
    chv = {CHANNELS{8'd200}};
    chv[7:0] = 8'd255;
    start_mix(chv, '0);
    drain();

    // 4: full-scale overflow (clamp or wrap)
    for (int k = 0; k < int'(CHANNELS); k++) write_gain(k, 15);
    start_mix(all255, '0);
    drain();

    // Random mixes with random gains and mutes
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < int'(CHANNELS); k++) write_gain(k, $urandom_range(15, 0));
      for (int k = 0; k < int'(CHANNELS); k++) chv[k*WIDTH +: WIDTH] = 8'($urandom_range(255, 0));
      start_mix(chv, 8'($urandom_range(255, 0)));
      drain();
    end
    check_val("overrun_clear", 32'(bus.overrun), 32'd0);

    // 5: tick while busy, live inputs changed mid-mix
    for (int k = 0; k < int'(CHANNELS); k++) write_gain(k, 8);
    start_mix(all255, '0);
    step();
    bus.channels = '0;
    step();
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
    check_val("overrun_set", 32'(bus.overrun), 32'd1);
    drain();
    repeat (12) step();
    check_val("overrun_sticky", 32'(bus.overrun), 32'd1);

    // 6: reset mid-mix abandons it and restores unity gains
    write_gain(2, 3);
    bus.channels = all255;
    bus.mute = '0;
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    reset_models();
    check_val("rst6_out", 32'(bus.out), 32'd0);
    check_val("rst6_busy", 32'(bus.busy), 32'd0);
    check_val("rst6_overrun", 32'(bus.overrun), 32'd0);
    repeat (12) step();
    check_val("rst6_out_still0", 32'(bus.out), 32'd0);
    start_mix(all255, '0);
    drain();
    repeat (12) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/audio_mixer_seq.md
Name: audio_mixer_seq

Overview:
Time-multiplexed, parametrised audio mixer that replaces the fixed 8-input combinational adder.
- On each sample strobe it snapshots CHANNELS unsigned inputs.
- Applies a per-channel register-programmed gain and a mute mask, accumulating one channel per clock.
- Emits a scaled, registered result with a one-cycle valid pulse.
- Sits between the sound-effect voice generators and the PWM/DAC output stage.

Parameters:
WIDTH, 8, bits per input channel sample (unsigned)
CHANNELS, 8, number of input channels (>=2)
GAIN_BITS, 4, per-channel gain width; unity gain = 2^(GAIN_BITS-1)
SHIFT, 2, right shift applied to the final accumulator
OUT_WIDTH, WIDTH+1, output sample width

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
sample_tick  input  1  one-cycle strobe requesting a new mix
channels  input  CHANNELS*WIDTH  channel k at [k*WIDTH +: WIDTH]
mute  input  CHANNELS  bit k=1 excludes channel k; sampled with channels
gain_we  input  1  gain register write enable
gain_sel  input  $clog2(CHANNELS)  channel index for gain write
gain_data  input  GAIN_BITS  gain value to write
out  output  OUT_WIDTH  mixed sample, held between updates
out_valid  output  1  one-cycle pulse when out updates
busy  output  1  high while a mix is in progress
overrun  output  1  sticky: sample_tick arrived while busy

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst is synchronous and active-high.
  - Reset values: out=0, out_valid=0, busy=0, overrun=0, state=IDLE, index=0, accumulator=0, every gain=2^(GAIN_BITS-1) (unity, 8 at default).
  - Reset mid-mix abandons the mix; no out_valid follows.
- FSM states: IDLE, ACCUM, DONE.
  - IDLE: sample_tick=1 at edge E snapshots channels and mute into internal registers, clears accumulator, index=0, goes to ACCUM. busy=0 in IDLE.
  - ACCUM: each edge adds contribution(index) and increments index. The edge that adds index=CHANNELS-1 moves to DONE. busy=1.
  - DONE: next edge loads out, pulses out_valid for exactly one cycle, returns to IDLE. busy=1.
  - Latency: out and out_valid update at edge E+CHANNELS+1 (E+9 at default). Minimum tick spacing is CHANNELS+2 cycles.
- Contribution of channel k:
  - 0 if the snapshot mute bit k=1.
  - Otherwise (sample_k * gain_k) >> (GAIN_BITS-1), computed at full width WIDTH+GAIN_BITS before shifting.
- Arithmetic widths and result:
  - Accumulator width: WIDTH+1+$clog2(CHANNELS); it never wraps.
  - Result = accumulator >> SHIFT, then reduced to OUT_WIDTH per the Optional Feature.
- Live inputs are not used during a mix: changes on channels/mute after edge E do not affect that mix.
- Tick while busy:
  - sample_tick during ACCUM or DONE is ignored and sets overrun=1.
  - overrun clears only on rst.
  - The ignored tick does not restart or alter the current mix.
- Gain writes:
  - gain_we=1 writes gain_data into gain[gain_sel] at that edge, in any state.
  - gain_sel >= CHANNELS is ignored.
  - A write at the same edge a channel is accumulated takes effect on the next mix; the old value is used for the current one.
- No combinational path from any input to any output.

Optional Feature:
AUDIO_MIXER_SATURATE_EN
- Defined: a result exceeding 2^OUT_WIDTH-1 clamps to 2^OUT_WIDTH-1 (all ones).
- Undefined: the result is truncated to its low OUT_WIDTH bits (wrap-around).
- Everything else is identical in both builds.

Test Plan:
1. After rst: out=0, out_valid=0, busy=0, overrun=0. Tick with all 8 channels=255, no mute -> out=510 at E+9, out_valid high exactly one cycle, busy high from E+1 to E+8 inclusive.
2. All channels=100, mute=8'b1111_0000 -> 4*100=400, >>2 -> out=100.
3. Write gain[0]=15, gain[1..7]=0; ch0=255 -> (255*15)>>3=478, >>2 -> out=119.
4. All gains=15, all channels=255 -> sum 3824, >>2 = 956 -> out=511 with AUDIO_MIXER_SATURATE_EN, out=444 without.
5. Tick, then second tick at E+3, and all channels changed to 0 at E+2 -> out still 510 (from scenario 1 inputs), only one out_valid pulse, overrun=1 and stays 1 until rst.
6. Program gain[2]=3, start a mix, assert rst at E+4 -> no out_valid afterwards, out=0, busy=0, gain[2] back to 8; a following tick with scenario 1 inputs yields 510.
